pong_game_engine: RTL and testbench

Parametrised Pong game core for two players. It consumes column/row counters from the VGA timing chain, the debounced paddle switches and a game-start pulse (UART RX data-valid). It produces a registered 1-bit draw signal, per-player scores and game state. Playfield size, tile size, paddle height, speeds and winning score are all parametrised; scoring and the win/game-over flow are new in this generation.

---
 rtl/pong_game_engine.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_pong_game_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_engine.sv
// rtl/pong_game_engine.sv - two-player Pong core driven by VGA column/row counters
//
// Purpose:
//   Keeps ball, paddle, score and game-state registers on a tile grid
//   (ACTIVE_COLS>>TILE_SHIFT x ACTIVE_ROWS>>TILE_SHIFT). Game state advances
//   only on a frame tick taken at the start of vertical blanking. Produces a
//   registered per-pixel draw bit (one cycle behind the counters).
//
// Ports:
//   i_Clk            pixel clock
//   i_Rst            synchronous reset, active-high
//   i_Col_Count      current pixel column (10 bits)
//   i_Row_Count      current pixel row (10 bits)
//   i_Game_Start     single-cycle start / restart pulse
//   i_Paddle_Up_P1   player 1 up, level
//   i_Paddle_Dn_P1   player 1 down, level
//   i_Paddle_Up_P2   player 2 up, level
//   i_Paddle_Dn_P2   player 2 down, level
//   o_Draw           pixel belongs to a paddle or the ball (registered)
//   o_Score_P1       player 1 points
//   o_Score_P2       player 2 points
//   o_State          0 IDLE, 1 RUNNING, 2 GAME_OVER
//
// Build option:
//   PONG_AI_P2_EN    when defined, player 2 ignores its switches and tracks the ball.

module pong_game_engine #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int TILE_SHIFT    = 4,
    parameter int PADDLE_HEIGHT = 6,
    parameter int PADDLE_SPEED  = 2,
    parameter int BALL_SPEED    = 3,
    parameter int WIN_SCORE     = 9
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [9:0] i_Col_Count,
    input  logic [9:0] i_Row_Count,
    input  logic       i_Game_Start,
    input  logic       i_Paddle_Up_P1,
    input  logic       i_Paddle_Dn_P1,
    input  logic       i_Paddle_Up_P2,
    input  logic       i_Paddle_Dn_P2,
    output logic       o_Draw,
    output logic [3:0] o_Score_P1,
    output logic [3:0] o_Score_P2,
    output logic [1:0] o_State
);

    localparam int GRID_COLS = ACTIVE_COLS >> TILE_SHIFT;
    localparam int GRID_ROWS = ACTIVE_ROWS >> TILE_SHIFT;

    localparam logic [5:0] COL_MAX     = 6'(GRID_COLS - 1);
    localparam logic [5:0] ROW_MAX     = 6'(GRID_ROWS - 1);
    localparam logic [5:0] BALL_X0     = 6'(GRID_COLS / 2);
    localparam logic [5:0] BALL_Y0     = 6'(GRID_ROWS / 2);
    localparam logic [5:0] PAD_MAX     = 6'(GRID_ROWS - PADDLE_HEIGHT);
    localparam logic [5:0] PAD_Y0      = 6'((GRID_ROWS - PADDLE_HEIGHT) / 2);
    localparam logic [5:0] PAD_H_M1    = 6'(PADDLE_HEIGHT - 1);
    localparam logic [7:0] PAD_SPD_M1  = 8'(PADDLE_SPEED - 1);
    localparam logic [7:0] BALL_SPD_M1 = 8'(BALL_SPEED - 1);
    localparam logic [3:0] WIN         = 4'(WIN_SCORE);
    localparam logic [9:0] ACT_COLS    = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS    = 10'(ACTIVE_ROWS);

    // The tick row only exists when the frame actually has a blanking region.
    localparam logic HAS_VBLANK = (ACTIVE_ROWS < TOTAL_ROWS) && (ACTIVE_COLS <= TOTAL_COLS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       tick_q;
    logic       draw_q;
    logic [5:0] ball_x_q, ball_y_q;
    logic       ball_dx_q;              // 1 = moving right (+x)
    logic       ball_dy_q;              // 1 = moving down (+y)
    logic [7:0] ball_cnt_q;
    logic [5:0] pad_top_q [2];          // index 0 = P1 (left), 1 = P2 (right)
    logic [7:0] pad_cnt_q [2];
    logic [3:0] score_q   [2];

    logic [5:0] pad_top_d [2];
    logic [7:0] pad_cnt_d [2];
    logic [1:0] pad_up, pad_dn;

    logic       dx_step, dy_step;
    logic [5:0] x_step, y_step;
    logic       point_p1, point_p2;
    logic       ball_fire;
    logic       restart;
    logic       p1_wins, p2_wins;
    logic [3:0] score_p1_inc, score_p2_inc;

    logic [9:0] tile_col, tile_row;
    logic       in_active, in_grid, ball_tile, p1_tile, p2_tile;
    logic       draw_d;

    function automatic logic in_paddle(input logic [5:0] y, input logic [5:0] top);
        return (y >= top) && (y <= top + PAD_H_M1);
    endfunction

    // Paddle control sources
    always_comb begin
        pad_up[0] = i_Paddle_Up_P1;
        pad_dn[0] = i_Paddle_Dn_P1;
`ifdef PONG_AI_P2_EN
        pad_up[1] = ball_y_q < pad_top_q[1];
        pad_dn[1] = ball_y_q > (pad_top_q[1] + PAD_H_M1);
`else
        pad_up[1] = i_Paddle_Up_P2;
        pad_dn[1] = i_Paddle_Dn_P2;
`endif
    end

`ifdef PONG_AI_P2_EN
    logic unused_p2_switches;
    assign unused_p2_switches = i_Paddle_Up_P2 | i_Paddle_Dn_P2;
`endif

    // Paddle step: one tile every PADDLE_SPEED ticks while exactly one
    // direction is held; conflicting or released switches clear the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pad_top_d[i] = pad_top_q[i];
            pad_cnt_d[i] = pad_cnt_q[i];
            if (pad_up[i] ^ pad_dn[i]) begin
                if (pad_cnt_q[i] == PAD_SPD_M1) begin
                    pad_cnt_d[i] = 8'd0;
                    if (pad_up[i] && pad_top_q[i] != 6'd0) begin
                        pad_top_d[i] = pad_top_q[i] - 6'd1;
                    end else if (pad_dn[i] && pad_top_q[i] != PAD_MAX) begin
                        pad_top_d[i] = pad_top_q[i] + 6'd1;
                    end
                end else begin
                    pad_cnt_d[i] = pad_cnt_q[i] + 8'd1;
                end
            end else begin
                pad_cnt_d[i] = 8'd0;
            end
        end
    end

    // Ball step: wall bounce, then paddle reflections, then the move itself.
    // Paddle checks use the paddle positions from before this tick.
    always_comb begin
        dy_step = ball_dy_q;
        if (ball_y_q == 6'd0 && !ball_dy_q) begin
            dy_step = 1'b1;
        end else if (ball_y_q == ROW_MAX && ball_dy_q) begin
            dy_step = 1'b0;
        end

        dx_step = ball_dx_q;
        if (ball_x_q == 6'd1 && !ball_dx_q && in_paddle(ball_y_q, pad_top_q[0])) begin
            dx_step = 1'b1;
        end else if (ball_x_q == COL_MAX - 6'd1 && ball_dx_q && in_paddle(ball_y_q, pad_top_q[1])) begin
            dx_step = 1'b0;
        end

        x_step = dx_step ? ball_x_q + 6'd1 : ((ball_x_q == 6'd0) ? 6'd0 : ball_x_q - 6'd1);
        y_step = dy_step ? ball_y_q + 6'd1 : ((ball_y_q == 6'd0) ? 6'd0 : ball_y_q - 6'd1);

        point_p2 = (x_step == 6'd0);
        point_p1 = (x_step == COL_MAX);
    end

    assign ball_fire    = tick_q && (state_q == ST_RUN) && (ball_cnt_q == BALL_SPD_M1);
    assign restart      = (state_q == ST_OVER) && i_Game_Start;
    assign score_p1_inc = (score_q[0] >= WIN) ? WIN : score_q[0] + 4'd1;
    assign score_p2_inc = (score_q[1] >= WIN) ? WIN : score_q[1] + 4'd1;
    assign p1_wins      = point_p1 && (score_p1_inc == WIN);
    assign p2_wins      = point_p2 && (score_p2_inc == WIN);

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_Game_Start) state_d = ST_RUN;
            ST_RUN: begin
                if (ball_fire && (point_p1 || point_p2)) begin
                    state_d = (p1_wins || p2_wins) ? ST_OVER : ST_IDLE;
                end
            end
            ST_OVER: if (i_Game_Start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pixel draw decision
    assign tile_col = i_Col_Count >> TILE_SHIFT;
    assign tile_row = i_Row_Count >> TILE_SHIFT;

    always_comb begin
        in_active = (i_Col_Count < ACT_COLS) && (i_Row_Count < ACT_ROWS);
        in_grid   = (tile_col[9:6] == 4'd0) && (tile_row[9:6] == 4'd0);
        ball_tile = (tile_col[5:0] == ball_x_q) && (tile_row[5:0] == ball_y_q);
        p1_tile   = (tile_col[5:0] == 6'd0) && in_paddle(tile_row[5:0], pad_top_q[0]);
        p2_tile   = (tile_col[5:0] == COL_MAX) && in_paddle(tile_row[5:0], pad_top_q[1]);
        draw_d    = in_active && in_grid && (ball_tile || p1_tile || p2_tile);
    end

    // Datapath registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tick_q     <= 1'b0;
            draw_q     <= 1'b0;
            ball_x_q   <= BALL_X0;
            ball_y_q   <= BALL_Y0;
            ball_dx_q  <= 1'b1;
            ball_dy_q  <= 1'b1;
            ball_cnt_q <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                pad_top_q[i] <= PAD_Y0;
                pad_cnt_q[i] <= 8'd0;
                score_q[i]   <= 4'd0;
            end
        end else begin
            tick_q <= HAS_VBLANK && (i_Col_Count == 10'd0) && (i_Row_Count == ACT_ROWS);
            draw_q <= draw_d;

            if (restart) begin
                for (int i = 0; i < 2; i++) begin
                    pad_top_q[i] <= PAD_Y0;
                    pad_cnt_q[i] <= 8'd0;
                    score_q[i]   <= 4'd0;
                end
            end else if (tick_q) begin
                for (int i = 0; i < 2; i++) begin
                    pad_top_q[i] <= pad_top_d[i];
                    pad_cnt_q[i] <= pad_cnt_d[i];
                end
            end

            if (state_q != ST_RUN) begin
                ball_cnt_q <= 8'd0;
            end else if (tick_q) begin
                ball_cnt_q <= (ball_cnt_q == BALL_SPD_M1) ? 8'd0 : ball_cnt_q + 8'd1;
            end

            if (ball_fire) begin
                ball_dy_q <= dy_step;
                if (point_p1 || point_p2) begin
                    // Serve toward the player who just conceded.
                    ball_x_q  <= BALL_X0;
                    ball_y_q  <= BALL_Y0;
                    ball_dx_q <= point_p1;
                    if (point_p1) begin
                        score_q[0] <= score_p1_inc;
                    end else begin
                        score_q[1] <= score_p2_inc;
                    end
                end else begin
                    ball_x_q  <= x_step;
                    ball_y_q  <= y_step;
                    ball_dx_q <= dx_step;
                end
            end
        end
    end

    assign o_Draw     = draw_q;
    assign o_Score_P1 = score_q[0];
    assign o_Score_P2 = score_q[1];
    assign o_State    = state_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb/tb_pong_game_engine.sv - randomized scoreboard bench for pong_game_engine
module tb_pong_game_engine;
    localparam int GC   = 40;
    localparam int GR   = 30;
    localparam int PH   = 6;
    localparam int PS   = 2;
    localparam int BS   = 3;
    localparam int WIN  = 3;
    localparam int TILE = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [9:0] col   = 10'd700;
    logic [9:0] row   = 10'd500;
    logic       start = 1'b0;
    logic       u1 = 1'b0, d1 = 1'b0, u2 = 1'b0, d2 = 1'b0;
    logic       draw;
    logic [3:0] s1, s2;
    logic [1:0] st;

    always #5 clk = ~clk;

    pong_game_engine #(.WIN_SCORE(WIN)) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Col_Count   (col),
        .i_Row_Count   (row),
        .i_Game_Start  (start),
        .i_Paddle_Up_P1(u1),
        .i_Paddle_Dn_P1(d1),
        .i_Paddle_Up_P2(u2),
        .i_Paddle_Dn_P2(d2),
        .o_Draw        (draw),
        .o_Score_P1    (s1),
        .o_Score_P2    (s2),
        .o_State       (st)
    );

    typedef struct packed {
        logic       draw;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference game model: signed directions, plain integer positions.
    int m_bx, m_by, m_dx, m_dy;
    int m_p1, m_p2, m_c1, m_c2, m_bc;
    int m_s1, m_s2, m_st;
    bit m_tick;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void model_reset();
        m_bx = GC / 2; m_by = GR / 2; m_dx = 1; m_dy = 1;
        m_p1 = (GR - PH) / 2; m_p2 = (GR - PH) / 2;
        m_c1 = 0; m_c2 = 0; m_bc = 0;
        m_s1 = 0; m_s2 = 0; m_st = 0; m_tick = 1'b0;
    endfunction

    function automatic bit model_draw(input int c, input int r);
        int tx, ty;
        if (c >= 640 || r >= 480) return 1'b0;
        tx = c / TILE;
        ty = r / TILE;
        return (tx == m_bx && ty == m_by) ||
               (tx == 0 && ty >= m_p1 && ty < m_p1 + PH) ||
               (tx == GC - 1 && ty >= m_p2 && ty < m_p2 + PH);
    endfunction

    task automatic paddle_step(inout int top, inout int cnt, input bit up, input bit dn);
        if (up != dn) begin
            cnt++;
            if (cnt == PS) begin
                cnt = 0;
                top = top + (up ? -1 : 1);
                if (top < 0) top = 0;
                if (top > GR - PH) top = GR - PH;
            end
        end else begin
            cnt = 0;
        end
    endtask

    task automatic ball_step();
        if ((m_by == 0 && m_dy < 0) || (m_by == GR - 1 && m_dy > 0)) m_dy = -m_dy;
        if (m_bx == 1 && m_dx < 0 && m_by >= m_p1 && m_by < m_p1 + PH) m_dx = 1;
        if (m_bx == GC - 2 && m_dx > 0 && m_by >= m_p2 && m_by < m_p2 + PH) m_dx = -1;
        m_bx += m_dx;
        m_by += m_dy;
        if (m_bx == 0) begin
            m_s2 = (m_s2 < WIN) ? m_s2 + 1 : WIN;
            m_bx = GC / 2; m_by = GR / 2; m_dx = -1;
            m_st = (m_s2 == WIN) ? 2 : 0;
        end else if (m_bx == GC - 1) begin
            m_s1 = (m_s1 < WIN) ? m_s1 + 1 : WIN;
            m_bx = GC / 2; m_by = GR / 2; m_dx = 1;
            m_st = (m_s1 == WIN) ? 2 : 0;
        end
    endtask

    task automatic model_tick();
        bit pu2, pd2;
`ifdef PONG_AI_P2_EN
        pu2 = m_by < m_p2;
        pd2 = m_by > m_p2 + PH - 1;
`else
        pu2 = u2;
        pd2 = d2;
`endif
        if (m_st == 1) begin
            m_bc++;
            if (m_bc == BS) begin
                m_bc = 0;
                ball_step();
            end
        end else begin
            m_bc = 0;
        end
        paddle_step(m_p1, m_c1, u1, d1);
        paddle_step(m_p2, m_c2, pu2, pd2);
    endtask

    task automatic model_start();
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 2) begin
            m_st = 0; m_s1 = 0; m_s2 = 0;
            m_p1 = (GR - PH) / 2; m_p2 = (GR - PH) / 2;
            m_c1 = 0; m_c2 = 0;
        end
    endtask

    // One clock cycle of stimulus; expectation is pushed for the monitor.
    task automatic cyc(input int c, input int r, input bit s);
        exp_t e;
        col   = 10'(c);
        row   = 10'(r);
        start = s;
        @(posedge clk);
        #1;
        e.draw = model_draw(c, r);
        if (rst) begin
            model_reset();
            e.draw = 1'b0;
        end else begin
            if (m_tick) model_tick();
            if (s) model_start();
            m_tick = (c == 0 && r == 480);
        end
        e.s1 = 4'(m_s1);
        e.s2 = 4'(m_s2);
        e.st = 2'(m_st);
        exp_q.push_back(e);
        start = 1'b0;
    endtask

    // Pixel probe that never lands on the tick position or off-screen negatives.
    task automatic probe(input int c, input int r, input bit s);
        if (c < 0) c = 0;
        if (r < 0) r = 0;
        if (c == 0 && r == 480) r = 481;
        cyc(c, r, s);
    endtask

    task automatic frame(input int nprobe, input bit start_at_end);
        cyc(0, 480, 1'b0);
        cyc(640, 490, 1'b0);
        probe(m_bx * TILE, m_by * TILE, 1'b0);
        probe(m_bx * TILE + 15, m_by * TILE + 15, 1'b0);
        probe(m_bx * TILE + 16, m_by * TILE + 7, 1'b0);
        probe(m_bx * TILE - 1, m_by * TILE + 7, 1'b0);
        probe($urandom_range(1, 15), m_p1 * TILE, 1'b0);
        probe($urandom_range(1, 15), m_p1 * TILE - 1, 1'b0);
        probe($urandom_range(1, 15), (m_p1 + PH) * TILE - 1, 1'b0);
        probe($urandom_range(1, 15), (m_p1 + PH) * TILE, 1'b0);
        probe($urandom_range(624, 639), m_p2 * TILE, 1'b0);
        probe($urandom_range(624, 639), (m_p2 + PH) * TILE, 1'b0);
        for (int k = 0; k < nprobe; k++) begin
            probe($urandom_range(0, 799), $urandom_range(0, 524), 1'b0);
        end
        probe(m_bx * TILE + 8, m_by * TILE + 8, start_at_end);
    endtask

    task automatic scan();
        int base, r;
        base = m_by * TILE;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       r = base - 1;
                1:       r = base;
                2:       r = base + 15;
                default: r = base + 16;
            endcase
            for (int c = 0; c < 800; c++) probe(c, r, 1'b0);
        end
        for (int c = 0; c < 800; c += 7) probe(c, 500, 1'b0);
    endtask

    task automatic set_inputs(input int mode);
        u1 = 1'b0; d1 = 1'b0; u2 = 1'b0; d2 = 1'b0;
        case (mode)
            1: begin
                u1 = 1'($urandom_range(0, 1)); d1 = 1'($urandom_range(0, 1));
                u2 = 1'($urandom_range(0, 1)); d2 = 1'($urandom_range(0, 1));
            end
            2: begin
                u1 = m_by < m_p1; d1 = m_by > m_p1 + PH - 1;
            end
            3: begin
                u1 = m_by < m_p1; d1 = m_by > m_p1 + PH - 1;
                u2 = m_by < m_p2; d2 = m_by > m_p2 + PH - 1;
            end
            default: ;
        endcase
    endtask

    task automatic random_play(input int nframes, input bit stop_at_over);
        int mode;
        bit want;
        mode = 0;
        for (int f = 0; f < nframes; f++) begin
            if (stop_at_over && m_st == 2) break;
            if (f % 25 == 0) mode = $urandom_range(0, 3);
            set_inputs(mode);
            want = (m_st == 0 && $urandom_range(0, 3) == 0) ||
                   (m_st == 1 && $urandom_range(0, 29) == 0);
            frame(3, want);
        end
    endtask

    // Monitor: one expectation per clock, compared away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("draw",     draw, e.draw);
                chk("score_p1", s1,   e.s1);
                chk("score_p2", s2,   e.s2);
                chk("state",    st,   e.st);
            end
        end
    end

    initial begin
        model_reset();

        rst = 1'b1;
        repeat (3) cyc(320, 240, 1'b0);
        rst = 1'b0;
        probe(320, 240, 1'b0);
        probe(8, 12 * TILE, 1'b0);
        probe(8, 12 * TILE - 1, 1'b0);

        // P1 holds Up: steps every 2 frames and clamps at the top.
        u1 = 1'b1;
        repeat (40) frame(2, 1'b0);
        d1 = 1'b1;
        repeat (6) frame(2, 1'b0);
        u1 = 1'b0;
        d1 = 1'b0;

        // First rally with idle paddles: ball runs past P2.
        frame(2, 1'b1);
        for (int i = 0; i < 400 && m_st == 1; i++) frame(2, 1'b0);
        chk("miss_state_idle", st, 0);
        chk("miss_score_p1", s1, 1);
        chk("miss_score_p2", s2, 0);
        probe(GC / 2 * TILE, GR / 2 * TILE, 1'b0);

        // Randomized play until someone wins.
        random_play(3000, 1'b1);
        chk("game_over_reached", st, 2);

        scan();

        set_inputs(0);
        frame(2, 1'b1);
        chk("restart_state", st, 0);
        chk("restart_score_p1", s1, 0);
        chk("restart_score_p2", s2, 0);
        frame(2, 1'b1);
        chk("start_to_running", st, 1);
        frame(2, 1'b1);
        chk("start_ignored_running", st, 1);

        random_play(700, 1'b0);

        // Reset while a rally is live.
        for (int i = 0; i < 3 && m_st != 1; i++) frame(1, 1'b1);
        set_inputs(1);
        frame(2, 1'b0);
        rst = 1'b1;
        repeat (3) cyc(m_bx * TILE, m_by * TILE, 1'b0);
        rst = 1'b0;
        chk("reset_state", st, 0);
        chk("reset_score_p1", s1, 0);
        chk("reset_draw", draw, 0);
        probe(320, 240, 1'b0);
        probe(8, 12 * TILE, 1'b0);
        probe(630, 17 * TILE + 15, 1'b0);
        probe(630, 18 * TILE, 1'b0);
        repeat (3) cyc(700, 500, 1'b0);

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
